// File: rtl/bidir_bus_controller.sv
// Sequences tri-state pad controls and active-low strobes for a shared bidirectional
// external data bus, arbitrating one write and one read requester.
module bidir_bus_controller #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned READ_CYCLES   = 2,
  parameter int unsigned TURN_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] pad_i,
  output logic [DATA_WIDTH-1:0] pad_t,
  input  logic [DATA_WIDTH-1:0] pad_o,
  output logic                  ext_we_n,
  output logic                  ext_oe_n
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] READ_LD   = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, TURN
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    last_wr, last_wr_n;
  logic [DATA_WIDTH-1:0]   pad_i_n;
  logic                    drive_n, we_n_n, oe_n_n, busy_n, wr_ack_n, rd_ack_n;
  logic                    capture;
  logic                    turn_last;

  // Next state, counter and grant bookkeeping; outputs derive from the next state
  // so every output is registered alongside the state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_wr_n = last_wr;
    pad_i_n   = pad_i;
    case (state)
      IDLE: begin
        if (wr_req && (!rd_req || !last_wr)) begin
          state_n   = WR_SETUP;
          cnt_n     = SETUP_LD;
          last_wr_n = 1'b1;
          pad_i_n   = wr_data;
        end else if (rd_req) begin
          state_n   = RD_STROBE;
          cnt_n     = READ_LD;
          last_wr_n = 1'b0;
        end
      end
      WR_SETUP: begin
        if (cnt == '0) begin
          state_n = WR_STROBE;
          cnt_n   = STROBE_LD;
        end else cnt_n = cnt - CW'(1);
      end
      WR_STROBE: begin
        if (cnt == '0) begin
          state_n = WR_HOLD;
          cnt_n   = HOLD_LD;
        end else cnt_n = cnt - CW'(1);
      end
      WR_HOLD, RD_STROBE: begin
        if (cnt == '0) begin
          state_n = TURN;
          cnt_n   = TURN_LD;
        end else cnt_n = cnt - CW'(1);
      end
      TURN: begin
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - CW'(1);
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    drive_n   = (state_n == WR_SETUP) || (state_n == WR_STROBE) || (state_n == WR_HOLD);
    we_n_n    = (state_n != WR_STROBE);
    oe_n_n    = (state_n != RD_STROBE);
    busy_n    = (state_n != IDLE);
    turn_last = (state_n == TURN) && (cnt_n == '0);
    wr_ack_n  = turn_last && last_wr_n;
    rd_ack_n  = turn_last && !last_wr_n;
    capture   = (state == RD_STROBE) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_wr  <= 1'b0;
      pad_i    <= '0;
      pad_t    <= '1;
      ext_we_n <= 1'b1;
      ext_oe_n <= 1'b1;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_wr  <= last_wr_n;
      pad_i    <= pad_i_n;
      pad_t    <= {DATA_WIDTH{~drive_n}};
      ext_we_n <= we_n_n;
      ext_oe_n <= oe_n_n;
      wr_ack   <= wr_ack_n;
      rd_ack   <= rd_ack_n;
      busy     <= busy_n;
      if (capture) rd_data <= pad_o;
    end
  end

endmodule

// File: tb/tb_bidir_bus_controller.sv
// Directed bench for bidir_bus_controller: default-timing instance plus a
// stretched-timing instance exercised with one write.
module tb_bidir_bus_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req, wr_ack, rd_ack, busy, ext_we_n, ext_oe_n;
  logic [7:0] wr_data, rd_data, pad_i, pad_t, pad_o;

  logic       wr_req2, wr_ack2, rd_ack2, busy2, we_n2, oe_n2;
  logic [7:0] wr_data2, rd_data2, pad_i2, pad_t2;
  logic       rd_req2 = 1'b0;
  logic [7:0] pad_o2  = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bidir_bus_controller u_dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .busy(busy),
    .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o), .ext_we_n(ext_we_n), .ext_oe_n(ext_oe_n)
  );

  bidir_bus_controller #(
    .DATA_WIDTH(8), .SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2),
    .READ_CYCLES(2), .TURN_CYCLES(3)
  ) u_dut2 (
    .clk(clk), .reset(reset), .wr_req(wr_req2), .wr_data(wr_data2), .wr_ack(wr_ack2),
    .rd_req(rd_req2), .rd_ack(rd_ack2), .rd_data(rd_data2), .busy(busy2),
    .pad_i(pad_i2), .pad_t(pad_t2), .pad_o(pad_o2), .ext_we_n(we_n2), .ext_oe_n(oe_n2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] ones;
    logic       wr_act, rd_act, prev_wr, prev_rd, bad, seen_ack;
    int         acks;
    logic [3:0] order;
    ones = 8'hFF;

    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00; pad_o = 8'h00;
    wr_req2 = 1'b0; wr_data2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {pad_t, pad_i, rd_data, ext_we_n, ext_oe_n, busy, wr_ack, rd_ack},
          {ones, 8'h00, 8'h00, 5'b11000});
    reset = 1'b0;

    // Idle after reset release
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", k), {pad_t, ext_we_n, ext_oe_n, busy, wr_ack, rd_ack},
            {ones, 5'b11000});
    end

    // Default write of 0xA5; data change after grant must be ignored
    wr_data = 8'hA5; wr_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) wr_data = 8'hFF;
      check($sformatf("wr_c%0d", k), {pad_t, pad_i, ext_we_n, ext_oe_n, busy, wr_ack, rd_ack},
            {(k <= 4) ? 8'h00 : ones, 8'hA5, !(k == 2 || k == 3), 1'b1, (k <= 5), (k == 5), 1'b0});
      if (wr_ack) wr_req = 1'b0;
    end
    wr_req = 1'b0;

    // Default read with pad_o = 0x3C
    pad_o = 8'h3C; rd_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rd_c%0d", k), {pad_t, rd_data, ext_we_n, ext_oe_n, busy, wr_ack, rd_ack},
            {ones, (k >= 3) ? 8'h3C : 8'h00, 1'b1, !(k <= 2), (k <= 3), 1'b0, (k == 3)});
      if (k == 3) begin rd_req = 1'b0; pad_o = 8'h00; end
    end

    // Both requests held, each re-raised after its ack
    pad_o = 8'h5A; wr_req = 1'b1; rd_req = 1'b1;
    acks = 0; order = 4'b0; prev_wr = 1'b0; prev_rd = 1'b0; bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      wr_act = (pad_t != ones) || !ext_we_n;
      rd_act = !ext_oe_n;
      if ((pad_t != ones && pad_t != 8'h00) || (wr_act && rd_act) || (!ext_we_n && pad_t != 8'h00) ||
          (prev_wr && rd_act) || (prev_rd && wr_act)) bad = 1'b1;
      prev_wr = wr_act; prev_rd = rd_act;
      if (wr_ack || rd_ack) begin
        order = {order[2:0], wr_ack};
        acks++;
      end
      wr_req = wr_ack ? 1'b0 : (acks < 3) && (wr_req || !wr_ack);
      rd_req = rd_ack ? 1'b0 : (acks < 3) ? 1'b1 : rd_req;
      if (acks < 3 && !wr_ack && !wr_req) wr_req = 1'b1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("arb_invariants", {31'b0, bad}, 32'd0);
    check("arb_ack_count", acks, 32'd4);
    check("arb_order_wrwr", {28'b0, order}, {28'b0, 4'b1010});
    check("arb_rd_data", {24'b0, rd_data}, {24'b0, 8'h5A});

    // Reset pulsed during the write strobe
    wr_data = 8'h77; wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_strobe", {pad_t, ext_we_n, busy}, {8'h00, 1'b0, 1'b1});
    reset = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    check("rst_abort", {pad_t, rd_data, ext_we_n, ext_oe_n, busy, wr_ack},
          {ones, 8'h00, 4'b1100});
    reset = 1'b0;
    seen_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_ack || busy) seen_ack = 1'b1;
    end
    check("rst_no_ack", {31'b0, seen_ack}, 32'd0);

    // Reset wins over a simultaneous request
    reset = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    check("rst_vs_req", {ext_oe_n, busy}, {1'b1, 1'b0});
    reset = 1'b0; rd_req = 1'b0;
    @(negedge clk);

    // Stretched timing: setup 3, strobe 4, hold 2, turn 3
    wr_data2 = 8'hC3; wr_req2 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("p_wr_c%0d", k), {pad_t2, pad_i2, we_n2, oe_n2, busy2, wr_ack2},
            {(k <= 9) ? 8'h00 : ones, 8'hC3, !(k >= 4 && k <= 7), 1'b1, (k <= 12), (k == 12)});
      if (wr_ack2) wr_req2 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bidir_bus_controller.md
Name: bidir_bus_controller

Overview:
Sequences a DATA_WIDTH-wide bank of tri-state I/O buffers that drive a shared bidirectional external data bus, such as an external SRAM or peripheral bus hung off the PicoBlaze port interface. It arbitrates between one write requester and one read requester. It generates the per-bit tri-state controls and the active-low write and output-enable strobes with programmable setup, strobe, hold and turnaround timing. It guarantees the pads never drive while the external device drives.

Parameters:
DATA_WIDTH, 8, width of bus and data ports
SETUP_CYCLES, 1, cycles bus is driven before ext_we_n falls (1..15)
STROBE_CYCLES, 2, cycles ext_we_n is low (1..15)
HOLD_CYCLES, 1, cycles bus stays driven after ext_we_n rises (1..15)
READ_CYCLES, 2, cycles ext_oe_n is low; sample taken on the last one (1..15)
TURN_CYCLES, 1, cycles the bus is released with no strobes before the next access (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_req  input  1  write request; held high until wr_ack
wr_data  input  DATA_WIDTH  write data; captured when the write is granted
wr_ack  output  1  one-cycle pulse: write complete
rd_req  input  1  read request; held high until rd_ack
rd_ack  output  1  one-cycle pulse: rd_data valid
rd_data  output  DATA_WIDTH  read result; holds until the next read
busy  output  1  high in every state except IDLE
pad_i  output  DATA_WIDTH  to buffer I inputs
pad_t  output  DATA_WIDTH  to buffer T inputs; all bits identical; 1 = high-Z
pad_o  input  DATA_WIDTH  from buffer O outputs
ext_we_n  output  1  external write strobe, active low
ext_oe_n  output  1  external output enable, active low

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- All outputs are registered.
- Values at reset: state IDLE, pad_t all 1, pad_i 0, ext_we_n 1, ext_oe_n 1, wr_ack 0, rd_ack 0, rd_data 0, busy 0, last_grant = READ.
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, TURN.
- A single 4-bit down-counter is loaded with (parameter − 1) on entry to each timed state. The state exits when the counter reaches 0.
- IDLE:
  - If only wr_req is high: grant the write.
  - If only rd_req is high: grant the read.
  - If both are high: grant the opposite of last_grant, then update last_grant.
- Write grant: capture wr_data into pad_i and go to WR_SETUP.
- WR_SETUP: pad_t = 0. Next state is WR_STROBE.
- WR_STROBE: pad_t = 0, ext_we_n = 0. Next state is WR_HOLD.
- WR_HOLD: pad_t = 0, ext_we_n = 1. Next state is TURN.
- Read grant: go to RD_STROBE.
- RD_STROBE: pad_t = 1, ext_oe_n = 0. On the final cycle, rd_data ← pad_o at the closing edge. Next state is TURN.
- TURN: pad_t = 1, both strobes high.
  - wr_ack or rd_ack (matching the completed access) is high during the final TURN cycle only.
  - Next state is IDLE.
  - The requester drops its request on the edge ending the ack cycle, so IDLE never re-grants a stale request.
- Latency with default parameters, counted from the edge that samples the request in IDLE:
  - Write: setup in cycle 1, we_n low in cycles 2–3, hold in cycle 4, turn plus wr_ack in cycle 5.
  - Read: oe_n low in cycles 1–2, rd_data updated at the end of cycle 2, turn plus rd_ack in cycle 3.
- Invariants:
  - pad_t = 0 only in WR_* states.
  - pad_t = 0 and ext_oe_n = 0 never occur together.
  - ext_we_n = 0 only when pad_t = 0.
  - At least TURN_CYCLES released cycles separate any two accesses.
- A request arriving while busy waits; no requests are queued beyond the held request lines.
- wr_data changes after the grant are ignored.
- Reset mid-access:
  - The next state is IDLE, pad_t goes to all 1 and both strobes go high on that edge.
  - No ack is issued for the aborted access.
  - rd_data is cleared to 0.
- If reset and a request are both high, reset wins.

Test Plan:
- Reset release, no requests -> pad_t=all 1, ext_we_n=1, ext_oe_n=1, busy=0, no acks for 20 cycles.
- wr_req with wr_data=0xA5 -> pad_i=0xA5 with pad_t=0 in cycles 1–4, ext_we_n=0 only in cycles 2–3, wr_ack in cycle 5, then IDLE.
- rd_req with the bench driving pad_o=0x3C during oe_n low -> ext_oe_n=0 in cycles 1–2, pad_t=1 throughout, rd_data=0x3C with rd_ack in cycle 3.
- wr_req and rd_req both held, each re-raised after its ack -> grant order W, R, W, R. Each access is separated by a TURN cycle, and pad_t=0 never overlaps ext_oe_n=0.
- reset pulsed during WR_STROBE (cycle 2) -> next cycle pad_t=all 1, ext_we_n=1, busy=0, and no wr_ack.
- Parameters SETUP=3, STROBE=4, HOLD=2, TURN=3 with a write -> we_n low in cycles 4–7, drive ends after cycle 9, wr_ack in cycle 12.
